// File: rtl/mem_access_pkg.sv
// Shared funct3 codes, FSM encoding and request-legality helper for mem_access_arb.
// Pure declarations: no latency, no flow control.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RESP_IF  = 3'd1,
    RESP_LD  = 3'd2,
    RESP_ST  = 3'd3,
    RESP_ERR = 3'd4
  } state_t;

  // Load/store attributes that must survive into the response cycle.
  typedef struct packed {
    logic [1:0] off;
    logic [2:0] funct3;
  } ls_cap_t;

  function automatic logic ls_req_err(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic illegal;
    logic misal;
    illegal = 1'b0;
    misal   = 1'b0;
    case (funct3)
      F3_B:          illegal = 1'b0;
      F3_H:          illegal = 1'b0;
      F3_W:          illegal = 1'b0;
      F3_BU, F3_HU:  illegal = we;
      default:       illegal = 1'b1;
    endcase
    if (funct3[1:0] == 2'b01) misal = off[0];
    if (funct3[1:0] == 2'b10) misal = (off != 2'b00);
    return illegal | misal;
  endfunction

endpackage

// File: rtl/mem_access_arb_ld_extend.sv
// Aligns the addressed byte/half/word out of a read word and sign/zero-extends it.
// Combinational, no flow control; unknown funct3 yields zero.
module ld_extend
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    ext_o    = '0;
    case (funct3_i)
      F3_B:    ext_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   ext_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    ext_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   ext_o = {{(XLEN-16){1'b0}}, half_sel};
      F3_W:    ext_o = word_i;
      default: ext_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_arb.sv
// Fetch/LSU arbiter onto one 1-cycle sync-read memory port; response 1 cycle after accept, 1 access/cycle.
// No backpressure: LSU always wins, fetch accepted only when LSU idle; optional MEM_PERF_CNT_EN counters.
module mem_access_arb
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_instr,
  input  logic              ls_valid,
  input  logic              ls_we,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic [XLEN-1:0]   ls_wdata,
  input  logic [2:0]        ls_funct3,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [XLEN-1:0]   ls_rdata,
  output logic              ls_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [XLEN-1:0]   mem_w_data,
  output logic [3:0]        mem_masking,
  output logic              mem_we_re,
  input  logic [XLEN-1:0]   mem_r_data
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  logic ls_acc;
  logic if_acc;
  logic ls_err_req;
  logic st_ok;
  logic ld_ok;

  logic [3:0]      lane_mask;
  logic [XLEN-1:0] lane_data;
  logic [XLEN-1:0] ld_ext;

  state_t  state_q, state_d;
  ls_cap_t cap_q, cap_d;
  logic    if_rvalid_q;
  logic    ls_rvalid_q;
  logic    ls_err_q;

  // Gating with rst_n keeps every request-side output at 0 during reset,
  // so a store presented in the reset cycle can never reach the memory.
  assign ls_acc     = rst_n & ls_valid;
  assign if_acc     = rst_n & if_valid & ~ls_valid;
  assign ls_err_req = ls_req_err(ls_we, ls_funct3, ls_addr[1:0]);
  assign st_ok      = ls_acc & ls_we & ~ls_err_req;
  assign ld_ok      = ls_acc & ~ls_we & ~ls_err_req;

  assign if_ready = if_acc;
  assign ls_ready = ls_acc;

  always_comb begin
    lane_mask = 4'b1111;
    lane_data = ls_wdata;
    case (ls_funct3[1:0])
      2'b00: begin
        lane_mask = 4'b0001 << ls_addr[1:0];
        lane_data = {4{ls_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = 4'b0011 << ls_addr[1:0];
        lane_data = {2{ls_wdata[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = ls_wdata;
      end
    endcase
  end

  always_comb begin
    mem_address = '0;
    mem_w_data  = '0;
    mem_masking = '0;
    mem_we_re   = 1'b0;
    if (ls_acc) begin
      mem_address = ls_addr[ADDR_W+1:2];
      mem_w_data  = lane_data;
    end else if (if_acc) begin
      mem_address = if_pc[ADDR_W+1:2];
    end
    if (st_ok) begin
      mem_masking = lane_mask;
      mem_we_re   = 1'b1;
    end
  end

  always_comb begin
    state_d = IDLE;
    cap_d   = cap_q;
    if (ls_acc) begin
      if (ls_err_req)  state_d = RESP_ERR;
      else if (ls_we)  state_d = RESP_ST;
      else             state_d = RESP_LD;
      cap_d = '{off: ls_addr[1:0], funct3: ls_funct3};
    end else if (if_acc) begin
      state_d = RESP_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      if_rvalid_q <= (state_d == RESP_IF);
      ls_rvalid_q <= (state_d == RESP_LD) || (state_d == RESP_ST) || (state_d == RESP_ERR);
      ls_err_q    <= (state_d == RESP_ERR);
    end
  end

  ld_extend #(.XLEN(XLEN)) u_ld_extend (
    .word_i   (mem_r_data),
    .offset_i (cap_q.off),
    .funct3_i (cap_q.funct3),
    .ext_o    (ld_ext)
  );

  assign if_rvalid = if_rvalid_q;
  assign if_instr  = if_rvalid_q ? mem_r_data : '0;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_err    = ls_err_q;
  assign ls_rdata  = (state_q == RESP_LD) ? ld_ext : '0;

  // Address bits above the memory depth wrap and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_pc[XLEN-1:ADDR_W+2], if_pc[1:0], ls_addr[XLEN-1:ADDR_W+2]};

`ifdef MEM_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, load_cnt_q, store_cnt_q, conflict_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= '0;
      load_cnt_q     <= '0;
      store_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (if_acc)               fetch_cnt_q    <= fetch_cnt_q + 32'd1;
      if (ld_ok)                load_cnt_q     <= load_cnt_q + 32'd1;
      if (st_ok)                store_cnt_q    <= store_cnt_q + 32'd1;
      if (if_valid && ls_valid) conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign load_cnt     = load_cnt_q;
  assign store_cnt    = store_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`else
  logic unused_ld_ok;
  assign unused_ld_ok = ld_ok;
`endif

endmodule

// File: tb/tb_mem_access_arb.sv
// Bench for mem_access_arb: directed steps then random traffic against a byte-array reference memory.
module tb_mem_access_arb;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid, if_ready, if_rvalid;
  logic [31:0] if_pc, if_instr;
  logic        ls_valid, ls_we, ls_ready, ls_rvalid, ls_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [2:0]  ls_funct3;
  logic [7:0]  mem_address;
  logic [31:0] mem_w_data, mem_r_data;
  logic [3:0]  mem_masking;
  logic        mem_we_re;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] fetch_cnt, load_cnt, store_cnt, conflict_cnt;
`endif

  always #5 clk = ~clk;

  mem_access_arb #(.ADDR_W(8), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_instr(if_instr),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_funct3(ls_funct3), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_address(mem_address), .mem_w_data(mem_w_data), .mem_masking(mem_masking),
    .mem_we_re(mem_we_re), .mem_r_data(mem_r_data)
`ifdef MEM_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .load_cnt(load_cnt), .store_cnt(store_cnt),
    .conflict_cnt(conflict_cnt)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_1234;
  endfunction

  // Memory harness: byte-lane writes, registered read.
  logic [31:0] hmem [256];
  logic        seeded = 1'b0;
  logic [31:0] wtmp;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) hmem[i] <= init_word(i);
      seeded <= 1'b1;
    end else begin
      if (mem_we_re) begin
        wtmp = hmem[mem_address];
        for (int j = 0; j < 4; j++)
          if (mem_masking[j]) wtmp[8*j +: 8] = mem_w_data[8*j +: 8];
        hmem[mem_address] <= wtmp;
      end
      mem_r_data <= hmem[mem_address];
    end
  end

  logic [7:0]  ref_mem [1024];
  int          checks = 0;
  int          failures = 0;
  logic        e_if_rv, e_ls_rv, e_err;
  logic [31:0] e_rdata, e_instr;
  int          n_fetch, n_load, n_store, n_conf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic ok;
    int   n;
    ok = we ? (f3 <= 3'd2) : (f3 <= 3'd5 && f3 != 3'd3);
    n  = 1 << f3[1:0];
    if (!ok) return 1'b1;
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    int          n, base;
    logic [31:0] v;
    n    = 1 << f3[1:0];
    base = int'(a & 32'h3FF);
    v    = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base+i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         output logic [3:0] msk, output logic [31:0] wd);
    int n, base, off;
    n    = 1 << f3[1:0];
    base = int'(a & 32'h3FF);
    off  = int'(a[1:0]);
    msk  = '0;
    wd   = '0;
    for (int j = 0; j < 4; j++) wd[8*j +: 8] = d[8*(j % n) +: 8];
    for (int i = 0; i < n; i++) begin
      msk[off+i]      = 1'b1;
      ref_mem[base+i] = d[8*i +: 8];
    end
  endtask

  // Called at a negedge: check last cycle's responses, present a request, check the port.
  task automatic step(input logic iv, input logic [31:0] pc, input logic lv, input logic we,
                      input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    logic        err, f_acc;
    logic [3:0]  emsk;
    logic [31:0] ewd;
    chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(e_ls_rv));
    chk("ls_err", 32'(ls_err), 32'(e_ls_rv & e_err));
    if (e_if_rv) chk("if_instr", if_instr, e_instr);
    if (e_ls_rv) chk("ls_rdata", ls_rdata, e_rdata);
    if_valid = iv; if_pc = pc;
    ls_valid = lv; ls_we = we; ls_addr = a; ls_wdata = d; ls_funct3 = f3;
    #1;
    f_acc = iv & ~lv;
    err   = m_err(we, f3, a);
    chk("if_ready", 32'(if_ready), 32'(f_acc));
    chk("ls_ready", 32'(ls_ready), 32'(lv));
    if (lv) chk("mem_address_ls", 32'(mem_address), (a >> 2) & 32'hFF);
    else if (f_acc) chk("mem_address_if", 32'(mem_address), (pc >> 2) & 32'hFF);
    e_instr = m_load(F3_W, pc);
    e_rdata = (lv && !we && !err) ? m_load(f3, a) : 32'h0;
    if (lv && we && !err) begin
      m_store(f3, a, d, emsk, ewd);
      chk("mem_we_re_st", 32'(mem_we_re), 32'd1);
      chk("mem_masking", 32'(mem_masking), 32'(emsk));
      chk("mem_w_data", mem_w_data, ewd);
    end else begin
      chk("mem_we_re_idle", 32'(mem_we_re), 32'd0);
      chk("mem_masking_idle", 32'(mem_masking), 32'd0);
    end
    e_if_rv = f_acc;
    e_ls_rv = lv;
    e_err   = err;
    n_fetch += int'(f_acc);
    n_load  += int'(lv && !we && !err);
    n_store += int'(lv && we && !err);
    n_conf  += int'(iv && lv);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = init_word(i) >> (8 * b);
    e_if_rv = 1'b0; e_ls_rv = 1'b0; e_err = 1'b0; e_rdata = '0; e_instr = '0;
    n_fetch = 0; n_load = 0; n_store = 0; n_conf = 0;
    if_valid = 1'b1; if_pc = 32'h40;
    ls_valid = 1'b1; ls_we = 1'b1; ls_addr = 32'h30; ls_wdata = 32'h1111_2222; ls_funct3 = F3_W;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_ls_ready", 32'(ls_ready), 32'd0);
    chk("rst_we_re", 32'(mem_we_re), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_w_data", mem_w_data, 32'd0);
    chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    @(negedge clk);
    if_valid = 1'b0; ls_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, F3_W);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h13, 32'h0000_00AB, F3_B);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0, F3_B);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h13, 32'h0, F3_BU);
    step(1'b1, 32'h40, 1'b1, 1'b0, 32'h10, 32'h0, F3_W);
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, F3_B);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h06, 32'h0, F3_W);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h05, 32'h1234_5678, F3_H);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0, F3_W);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h08, 32'h0, 3'b011);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 32'hCAFE_F00D, F3_BU);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h08, 32'h0, F3_W);
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FC22, 32'h0000_BEEF, F3_H);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h22, 32'h0, F3_H);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h22, 32'h0, F3_HU);
    step(1'b1, 32'h0000_0410, 1'b0, 1'b0, 32'h0, 32'h0, F3_B);

    // Reset in the middle of a load response, with a store presented in the reset cycle.
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, F3_W);
    chk("pre_rst_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("pre_rst_ls_rdata", ls_rdata, e_rdata);
    rst_n = 1'b0;
    ls_valid = 1'b1; ls_we = 1'b1; ls_addr = 32'h24; ls_wdata = 32'h5555_AAAA; ls_funct3 = F3_W;
    #1;
    chk("rst_drop_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("rst_drop_ls_rdata", ls_rdata, 32'd0);
    chk("rst_store_we_re", 32'(mem_we_re), 32'd0);
    chk("rst_store_ready", 32'(ls_ready), 32'd0);
    @(negedge clk);
    ls_valid = 1'b0;
    rst_n = 1'b1;
    e_if_rv = 1'b0; e_ls_rv = 1'b0; e_err = 1'b0;
    n_fetch = 0; n_load = 0; n_store = 0; n_conf = 0;
    idle();
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, F3_W);

    for (int k = 0; k < 400; k++) begin
      logic        iv, lv, we;
      logic [2:0]  f3;
      logic [31:0] a, pc, d;
      iv = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      d  = $urandom;
      pc = $urandom & 32'hFFFF_FFFC;
      a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0 && f3[1:0] != 2'b11)
        a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      step(iv, pc, lv, we, a, d, f3);
    end
    idle();

`ifdef MEM_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'(n_fetch));
    chk("load_cnt", load_cnt, 32'(n_load));
    chk("store_cnt", store_cnt, 32'(n_store));
    chk("conflict_cnt", conflict_cnt, 32'(n_conf));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
